// File: rtl/axis_serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_serdes_pkg
// Description : Shared types, constants and helpers for the AXIS serializer
//               arbiter path (frame header format, FSM states, word sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package axis_serdes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } ser_state_t;

  // MSB of every header byte; data bytes carry no such marker position.
  localparam logic HDR_MARK = 1'b1;

  // Channel header byte: marker bit followed by the 7-bit source id.
  function automatic byte_t hdr_byte(input logic [6:0] id);
    return {HDR_MARK, id};
  endfunction

  // Number of payload bytes carried per word.
  function automatic int BYTES_PER_WORD(input int logic_size);
    return logic_size / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches the request vector
//               upward from ptr (wrapping) and returns the first requester as
//               an index and as a one-hot vector. The pointer lives in the
//               parent so this block stays purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic [NUM_REQ-1:0]         grant_onehot,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  int          idx;
  logic [IW-1:0] idx_w;

  // First requester at or above ptr, modulo NUM_REQ (works for non-power-of-two counts)
  always_comb begin
    grant_idx    = '0;
    grant_onehot = '0;
    any          = 1'b0;
    idx          = 0;
    idx_w        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = IW'(idx);
      if (!any && req[idx_w]) begin
        any                 = 1'b1;
        grant_idx           = idx_w;
        grant_onehot[idx_w] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_ser_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_ser_arbiter
// Description : Round-robin scheduler sharing the byte-wide aFIFO write port
//               between NUM_REQ word sources. Each accepted word is emitted as
//               a channel header byte followed by the word bytes LSB-first,
//               throttled by the aFIFO full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_ser_arbiter
  import axis_serdes_pkg::*;
#(
  parameter int LOGIC_SIZE = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_reset_n,
  input  logic [NUM_REQ-1:0]              s_valid,
  input  logic [NUM_REQ*LOGIC_SIZE-1:0]   s_tdata,
  output logic [NUM_REQ-1:0]              s_ready,
  output logic [7:0]                      o_to_fifo,
  output logic                            w_req,
  input  logic                            w_full,
  output logic [$clog2(NUM_REQ)-1:0]      o_grant,
  output logic                            o_busy
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int BPW = BYTES_PER_WORD(LOGIC_SIZE);
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

  ser_state_t          state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       grant_q;
  logic [BIW-1:0]      byte_idx;
  logic [LOGIC_SIZE-1:0] word_q;

  logic [IW-1:0]       pick;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                pick_any;
  logic [LOGIC_SIZE-1:0] sel_word;
  byte_t               data_byte;
  logic                accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req          (s_valid),
    .ptr          (rr_ptr),
    .grant_idx    (pick),
    .grant_onehot (pick_onehot),
    .any          (pick_any)
  );

  // Accept only from IDLE; reset gating keeps s_ready low while reset is held
  assign accept  = (state == IDLE) && pick_any && m_axis_reset_n;
  assign s_ready = accept ? pick_onehot : '0;

  assign w_req   = (state != IDLE) && !w_full;
  assign o_busy  = (state != IDLE);
  assign o_grant = grant_q;

  // Word of the source being picked this cycle
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IW'(i)) begin
        sel_word = s_tdata[i*LOGIC_SIZE +: LOGIC_SIZE];
      end
    end
  end

  // Current payload byte of the latched word
  always_comb begin
    data_byte = '0;
    for (int k = 0; k < BPW; k++) begin
      if (byte_idx == BIW'(k)) begin
        data_byte = word_q[k*8 +: 8];
      end
    end
  end

  // Byte presented to the aFIFO; held unchanged while w_full stalls the frame
  always_comb begin
    case (state)
      HDR:     o_to_fifo = hdr_byte(7'(grant_q));
      DATA:    o_to_fifo = data_byte;
      default: o_to_fifo = '0;
    endcase
  end

  // Frame FSM: latch word on accept, then step header and data bytes on each write
  always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
    if (!m_axis_reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      byte_idx <= '0;
      word_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_q   <= sel_word;
            grant_q  <= pick;
            rr_ptr   <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (w_req) begin
            byte_idx <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_req) begin
            if (byte_idx == BIW'(BPW - 1)) begin
              byte_idx <= '0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_ser_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_ser_arbiter
// Description : Directed self-checking bench for axis_ser_arbiter
//               (NUM_REQ=4, LOGIC_SIZE=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_ser_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int LOGIC_SIZE = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   s_valid;
  logic [127:0] s_tdata;
  logic [3:0]   s_ready;
  logic [7:0]   o_to_fifo;
  logic         w_req;
  logic         w_full;
  logic [1:0]   o_grant;
  logic         o_busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0] cap_b[$];
  int         cap_c[$];

  axis_ser_arbiter #(
    .LOGIC_SIZE (LOGIC_SIZE),
    .NUM_REQ    (NUM_REQ)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_reset_n (rst_n),
    .s_valid        (s_valid),
    .s_tdata        (s_tdata),
    .s_ready        (s_ready),
    .o_to_fifo      (o_to_fifo),
    .w_req          (w_req),
    .w_full         (w_full),
    .o_grant        (o_grant),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  // cycle stamp for write timing
  always @(posedge clk) cyc <= cyc + 1;

  // record every byte actually written to the aFIFO
  always @(negedge clk) begin
    if (rst_n && w_req) begin
      cap_b.push_back(o_to_fifo);
      cap_c.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = '0;
    s_tdata = '0;
    w_full  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 4'hF;
    s_tdata = '0;
    w_full  = 1'b0;
    tick();
    @(negedge clk);
    vectors++;
    if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_s_ready: got %b want 0000", s_ready); end
    vectors++;
    if (w_req !== 1'b0) begin miscompares++; $display("FAIL reset_w_req: got %b want 0", w_req); end
    vectors++;
    if (o_to_fifo !== 8'h00) begin miscompares++; $display("FAIL reset_o_to_fifo: got %h want 00", o_to_fifo); end
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_o_busy: got %b want 0", o_busy); end
    vectors++;
    if (o_grant !== 2'd0) begin miscompares++; $display("FAIL reset_o_grant: got %0d want 0", o_grant); end
    s_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp[5] = '{8'h82, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    s_tdata[2*32 +: 32] = 32'hDDCCBBAA;
    s_valid = 4'b0100;
    @(negedge clk);
    vectors++;
    if (s_ready !== 4'b0100) begin miscompares++; $display("FAIL single_accept: s_ready got %b want 0100", s_ready); end
    tick();
    s_valid = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({w_req, o_to_fifo} !== {1'b1, exp[k]} || s_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL single_byte%0d: got w_req=%b byte=%h s_ready=%b want 1 %h 0000", k, w_req, o_to_fifo, s_ready, exp[k]);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (o_busy !== 1'b0 || w_req !== 1'b0) begin miscompares++; $display("FAIL single_end: busy=%b w_req=%b want 0 0", o_busy, w_req); end
    vectors++;
    if (o_grant !== 2'd2) begin miscompares++; $display("FAIL single_grant: got %0d want 2", o_grant); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [39:0] got;
    logic [39:0] want;
    int id;
    int lag_ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_tdata[i*32 +: 32] = {8'(16*i+3), 8'(16*i+2), 8'(16*i+1), 8'(16*i)};
    end
    cap_b.delete();
    cap_c.delete();
    s_valid = 4'hF;
    repeat (30) tick();
    s_valid = '0;
    repeat (2) tick();
    vectors++;
    if (cap_b.size() != 25) begin miscompares++; $display("FAIL rr_count: got %0d writes want 25", cap_b.size()); end
    if (cap_b.size() >= 25) begin
      for (int f = 0; f < 5; f++) begin
        id     = f % 4;
        want   = {8'h80 | 8'(id), 8'(16*id), 8'(16*id+1), 8'(16*id+2), 8'(16*id+3)};
        got    = {cap_b[5*f], cap_b[5*f+1], cap_b[5*f+2], cap_b[5*f+3], cap_b[5*f+4]};
        lag_ok = 1;
        for (int j = 0; j < 5; j++) begin
          if (cap_c[5*f+j] - cap_c[0] != 6*f + j) lag_ok = 0;
        end
        vectors++;
        if (got !== want || lag_ok == 0) begin
          miscompares++;
          $display("FAIL rr_frame%0d: got %h timing_ok=%0d want %h timing_ok=1", f, got, lag_ok, want);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    logic [39:0] got;
    do_reset();
    cap_b.delete();
    cap_c.delete();
    s_tdata[0 +: 32] = 32'hDDCCBBAA;
    for (int c = 0; c < 10; c++) begin
      s_valid = (c == 0) ? 4'b0001 : 4'b0000;
      w_full  = (c >= 3 && c <= 5);
      @(negedge clk);
      if (c == 0) begin
        vectors++;
        if (s_ready !== 4'b0001) begin miscompares++; $display("FAIL stall_accept: s_ready got %b want 0001", s_ready); end
      end
      if (c >= 3 && c <= 5) begin
        vectors++;
        if ({w_req, o_to_fifo} !== {1'b0, 8'hBB}) begin
          miscompares++;
          $display("FAIL stall_hold_c%0d: got w_req=%b byte=%h want 0 bb", c, w_req, o_to_fifo);
        end
      end
      if (c == 8) begin
        vectors++;
        if (o_busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy_last: got %b want 1", o_busy); end
      end
      if (c == 9) begin
        vectors++;
        if (o_busy !== 1'b0) begin miscompares++; $display("FAIL stall_done: busy got %b want 0", o_busy); end
      end
      tick();
    end
    w_full = 1'b0;
    got = '0;
    if (cap_b.size() == 5) got = {cap_b[0], cap_b[1], cap_b[2], cap_b[3], cap_b[4]};
    vectors++;
    if (cap_b.size() != 5 || got !== 40'h80AABBCCDD) begin
      miscompares++;
      $display("FAIL stall_frame: got %0d writes %h want 5 writes 80aabbccdd", cap_b.size(), got);
    end
  endtask

  task automatic test_toggle();
    logic [39:0] got;
    cap_b.delete();
    cap_c.delete();
    s_tdata[1*32 +: 32] = 32'h44332211;
    for (int c = 0; c < 15; c++) begin
      s_valid = (c == 0) ? 4'b0010 : 4'b0000;
      w_full  = (c % 2 == 1);
      tick();
    end
    w_full = 1'b0;
    repeat (2) tick();
    got = '0;
    if (cap_b.size() == 5) got = {cap_b[0], cap_b[1], cap_b[2], cap_b[3], cap_b[4]};
    vectors++;
    if (cap_b.size() != 5 || got !== 40'h8111223344) begin
      miscompares++;
      $display("FAIL toggle_frame: got %0d writes %h want 5 writes 8111223344", cap_b.size(), got);
    end
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL toggle_idle: busy got %b want 0", o_busy); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    cap_b.delete();
    cap_c.delete();
    s_tdata[1*32 +: 32] = 32'h55667788;
    s_valid = 4'b0010;
    @(negedge clk);
    vectors++;
    if (s_ready !== 4'b0010) begin miscompares++; $display("FAIL mid_accept: s_ready got %b want 0010", s_ready); end
    tick();
    @(negedge clk);
    vectors++;
    if ({w_req, o_to_fifo} !== {1'b1, 8'h81}) begin
      miscompares++;
      $display("FAIL mid_header: got w_req=%b byte=%h want 1 81", w_req, o_to_fifo);
    end
    tick();
    rst_n   = 1'b0;
    s_valid = 4'b0011;
    #1;
    vectors++;
    if ({w_req, o_to_fifo, s_ready, o_busy} !== 14'd0) begin
      miscompares++;
      $display("FAIL mid_async_reset: got w_req=%b byte=%h s_ready=%b busy=%b want all 0", w_req, o_to_fifo, s_ready, o_busy);
    end
    tick();
    tick();
    vectors++;
    if (cap_b.size() != 1) begin miscompares++; $display("FAIL mid_dropped: got %0d writes want 1", cap_b.size()); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_regrant: s_ready got %b want 0001", s_ready); end
    tick();
    s_valid = '0;
    @(negedge clk);
    vectors++;
    if ({o_grant, o_to_fifo} !== {2'd0, 8'h80}) begin
      miscompares++;
      $display("FAIL mid_regrant_hdr: got grant=%0d byte=%h want 0 80", o_grant, o_to_fifo);
    end
    repeat (6) tick();
  endtask

  task automatic test_hold_until_idle();
    do_reset();
    s_tdata[0 +: 32]    = 32'h01234567;
    s_tdata[3*32 +: 32] = 32'h89ABCDEF;
    for (int c = 0; c < 8; c++) begin
      if (c == 0)      s_valid = 4'b0001;
      else if (c <= 6) s_valid = 4'b1000;
      else             s_valid = 4'b0000;
      @(negedge clk);
      if (c == 0) begin
        vectors++;
        if (s_ready !== 4'b0001) begin miscompares++; $display("FAIL hold_first: s_ready got %b want 0001", s_ready); end
      end else if (c <= 5) begin
        vectors++;
        if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL hold_busy_c%0d: s_ready got %b want 0000", c, s_ready); end
      end else if (c == 6) begin
        vectors++;
        if (s_ready !== 4'b1000) begin miscompares++; $display("FAIL hold_accept: s_ready got %b want 1000", s_ready); end
      end else begin
        vectors++;
        if ({w_req, o_to_fifo} !== {1'b1, 8'h83}) begin
          miscompares++;
          $display("FAIL hold_header: got w_req=%b byte=%h want 1 83", w_req, o_to_fifo);
        end
      end
      tick();
    end
    repeat (6) tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = '0;
    s_tdata = '0;
    w_full  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_toggle();
    test_reset_midframe();
    test_hold_until_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_ser_arbiter.md
# axis_ser_arbiter

Round-robin scheduler that shares the single byte-wide asynchronous-FIFO write port of the serializer path between `NUM_REQ` AXIS word sources. It accepts one `LOGIC_SIZE`-bit word from the granted source and writes a channel header byte to the aFIFO, followed by the word's bytes LSB-first. Back-pressure comes from the aFIFO full flag. Downstream, the deserializer can then demultiplex the bytes by channel. It sits in the write clock domain, between the AXIS sources and the aFIFO.

## Interface
Parameters:
- `LOGIC_SIZE`, 32: word width in bits; must be a multiple of 8, and at least 8.
- `NUM_REQ`, 4: number of requesting sources; range 2..128.

Ports:
- `m_axis_aclk`  in  1  clock; the only clock.
- `m_axis_reset_n`  in  1  reset; asynchronous and active-low.
- `s_valid`  in  `NUM_REQ`  per-source word valid.
- `s_tdata`  in  `NUM_REQ*LOGIC_SIZE`  per-source word; source i occupies bits `[i*LOGIC_SIZE +: LOGIC_SIZE]`.
- `s_ready`  out  `NUM_REQ`  per-source accept strobe, one-hot or zero.
- `o_to_fifo`  out  8  byte to the aFIFO.
- `w_req`  out  1  aFIFO write enable.
- `w_full`  in  1  aFIFO full flag.
- `o_grant`  out  `$clog2(NUM_REQ)`  index of the current or last granted source.
- `o_busy`  out  1  high while a frame is being emitted.

## Operation
- A frame is `1 + LOGIC_SIZE/8` bytes:
  - The header byte is `{1'b1, 7'(id)}`.
  - Data bytes follow, `tdata[k*8 +: 8]` for k = 0 .. `LOGIC_SIZE/8 - 1`.
- FSM states are IDLE, HDR and DATA.
- IDLE:
  - If any `s_valid` bit is high, pick the first valid source searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Assert `s_ready[g]` combinationally in that same cycle.
  - Latch the word into `word_q` and `g` into `o_grant`.
  - Set `rr_ptr <= (g+1) mod NUM_REQ`.
  - Go to HDR.
- HDR: `o_to_fifo` = header. When `w_req` is high, go to DATA with `byte_idx = 0`.
- DATA:
  - `o_to_fifo = word_q[byte_idx*8 +: 8]`.
  - On `w_req`, increment `byte_idx`.
  - On `w_req` with `byte_idx == LOGIC_SIZE/8-1`, go to IDLE.
- `w_req = (state != IDLE) && !w_full`. A byte is consumed only in a cycle where `w_req` is high.
- `o_busy = (state != IDLE)`.
- `s_ready` is all-zero outside IDLE. A valid held through a frame is not accepted until the next IDLE.
- Sources need not hold `tdata` after the accept cycle.
- `o_to_fifo` is 0 in IDLE.
- Fairness: a continuously valid source waits at most `NUM_REQ-1` frames.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, `rr_ptr` = 0, `o_grant` = 0, `byte_idx` = 0.
  - `s_ready` = 0, `w_req` = 0, `o_to_fifo` = 0, `o_busy` = 0.
- Reset mid-frame: the remaining bytes are dropped, nothing more is written, and `rr_ptr` returns to 0.
- Accept in cycle t:
  - Header is written at t+1.
  - Data bytes are written at t+2 .. t+1+`LOGIC_SIZE/8`, provided `w_full` is low throughout.
  - IDLE is reached at t+2+`LOGIC_SIZE/8`; the next accept can happen in that cycle.
  - Peak rate is one 32-bit word per 6 cycles.
- `w_full` high:
  - `w_req` is low in that cycle.
  - `o_to_fifo`, `byte_idx` and state hold.
  - Each held cycle adds one cycle of latency.
- `w_full` is sampled combinationally. It may toggle every cycle, and no byte is lost or duplicated.
- If `s_valid` drops in the cycle after a grant, the in-flight frame is unaffected.

## Structure
- Package `axis_serdes_pkg` contains:
  - `byte_t`.
  - `ser_state_t` enum {IDLE, HDR, DATA}.
  - `HDR_MARK = 1'b1`.
  - Function `hdr_byte(id)`.
  - The `BYTES_PER_WORD(LOGIC_SIZE)` constant.
- Sub-module `rr_arbiter #(NUM_REQ)`: a combinational pick of grant index plus a one-hot `any` flag, given the request vector and `rr_ptr`. The pointer register is kept in the parent.
- The parent holds the FSM, `word_q`, `byte_idx` and `rr_ptr`.

## Test plan
- Single source: `NUM_REQ`=4, source 2 presents 0xDDCCBBAA with `w_full`=0.
  - `s_ready` = 4'b0100 for 1 cycle.
  - Bytes written: 0x82, 0xAA, 0xBB, 0xCC, 0xDD on 5 consecutive cycles.
  - `o_busy` is low in the 6th cycle.
- All four sources valid continuously, each with a unique word: grants follow 0,1,2,3,0. Each frame is 5 bytes, with no interleaving and no gaps.
- `w_full` = 1 for 3 cycles during byte index 1:
  - `o_to_fifo` holds 0xBB with `w_req`=0.
  - The frame completes 3 cycles late and has exactly 5 writes.
- `w_full` toggling every cycle across a frame: exactly 5 writes, in order, with no duplicates.
- Reset asserted after the header of a source-1 frame:
  - `w_req`, `o_to_fifo` and `s_ready` go to 0 immediately.
  - After release, with sources 0 and 1 valid, source 0 is granted first.
- Source 3 valid while a source-0 frame is in flight: `s_ready[3]` stays 0 until IDLE, then pulses for one cycle. Header 0x83 follows.
